// File: rtl/pser_tx_fifo.sv
// Parallel-to-serial transmitter: item FIFO feeding a framed serial shifter.
// Frame = one all-ones start beat, BEATS data beats (LSB first across LANES), one zero stop beat.
module pser_tx_fifo #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LANES = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     req,
    input  logic [WIDTH-1:0]         parallel_in,
    output logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     channel_busy,
    output logic [LANES-1:0]         serial_out,
    output logic                     frame_active,
    output logic                     frame_done
);

    localparam int unsigned BEATS  = WIDTH / LANES;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // FIFO storage and bookkeeping
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push_c;
    logic             pop_c;

    // Serializer state
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [LANES-1:0] serial_out_q, serial_out_d;
    logic             frame_active_q, frame_active_d;
    logic             frame_done_q, frame_done_d;
    logic             start_ok_c;

    // Full flag comes straight from the count so a same-edge pop never frees a slot early
    assign tx_busy    = (count_q == CNT_W'(DEPTH));
    assign push_c     = req && !tx_busy;
    assign start_ok_c = (count_q != '0) && en && !channel_busy;

    assign fifo_count   = count_q;
    assign overflow     = overflow_q;
    assign serial_out   = serial_out_q;
    assign frame_active = frame_active_q;
    assign frame_done   = frame_done_q;

    // FIFO pointer, count and sticky overflow next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || (req && tx_busy);
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= parallel_in;
        end
    end

    // Frame sequencer next-state and registered-output values
    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        beat_d         = beat_q;
        serial_out_d   = '0;
        frame_active_d = 1'b0;
        frame_done_d   = 1'b0;
        pop_c          = 1'b0;
        case (state_q)
            S_IDLE, S_STOP: begin
                if (start_ok_c) begin
                    state_d        = S_START;
                    pop_c          = 1'b1;
                    shift_d        = mem_q[rd_ptr_q];
                    beat_d         = '0;
                    serial_out_d   = '1;
                    frame_active_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                state_d        = S_SHIFT;
                serial_out_d   = shift_q[LANES-1:0];
                shift_d        = shift_q >> LANES;
                beat_d         = '0;
                frame_active_d = 1'b1;
            end
            S_SHIFT: begin
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    state_d      = S_STOP;
                    frame_done_d = 1'b1;
                end else begin
                    serial_out_d   = shift_q[LANES-1:0];
                    shift_d        = shift_q >> LANES;
                    beat_d         = beat_q + BEAT_W'(1);
                    frame_active_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame sequencer state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            shift_q        <= '0;
            beat_q         <= '0;
            serial_out_q   <= '0;
            frame_active_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            beat_q         <= beat_d;
            serial_out_q   <= serial_out_d;
            frame_active_q <= frame_active_d;
            frame_done_q   <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_pser_tx_fifo.sv
// Bench for pser_tx_fifo: one single-lane and one four-lane instance share stimulus;
// each has a queue-based frame model and a monitor that rebuilds items from serial beats.
module tb_pser_tx_fifo;

    localparam int unsigned WIDTH = 40;
    localparam int unsigned DEPTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic             req = 1'b0;
    logic             channel_busy = 1'b0;
    logic [WIDTH-1:0] parallel_in = '0;

    logic       busy_w [2];
    logic       ovf_w  [2];
    logic       act_w  [2];
    logic       done_w [2];
    logic [3:0] cnt_w  [2];
    logic [3:0] ser_w  [2];
    logic [0:0] ser0;
    logic [3:0] ser1;

    int n_pass  = 0;
    int n_total = 0;
    bit end_chk = 1'b0;

    always #5 clk = ~clk;

    pser_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(1)) u_l1 (
        .clk(clk), .reset(reset), .en(en), .req(req), .parallel_in(parallel_in),
        .tx_busy(busy_w[0]), .fifo_count(cnt_w[0]), .overflow(ovf_w[0]),
        .channel_busy(channel_busy), .serial_out(ser0),
        .frame_active(act_w[0]), .frame_done(done_w[0])
    );

    pser_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(4)) u_l4 (
        .clk(clk), .reset(reset), .en(en), .req(req), .parallel_in(parallel_in),
        .tx_busy(busy_w[1]), .fifo_count(cnt_w[1]), .overflow(ovf_w[1]),
        .channel_busy(channel_busy), .serial_out(ser1),
        .frame_active(act_w[1]), .frame_done(done_w[1])
    );

    assign ser_w[0] = {3'b000, ser0};
    assign ser_w[1] = ser1;

    task automatic chk(input string nm, input int d, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", nm, d, got, want);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_sb
        localparam int L = (g == 0) ? 1 : 4;
        localparam int B = 40 / L;
        localparam logic [3:0] ONES = 4'((1 << L) - 1);

        logic [WIDTH-1:0] mq  [$];
        logic [WIDTH-1:0] exq [$];
        int               pos = -1;
        bit               ovf = 1'b0;
        int               mpos = -1;
        logic [WIDTH-1:0] acc = '0;
        bit               ended = 1'b0;

        // Model: FIFO as a queue, frame as a position on a BEATS+2 cycle timeline
        always @(posedge clk or posedge reset) begin
            if (reset) begin
                mq.delete();
                exq.delete();
                pos = -1;
                ovf = 1'b0;
            end else begin
                int sz;
                bit take;
                sz   = mq.size();
                take = req && (sz < int'(DEPTH));
                if (req && !take) ovf = 1'b1;
                if (sz > 0 && en && !channel_busy && (pos < 0 || pos == B + 1)) begin
                    exq.push_back(mq.pop_front());
                    pos = 0;
                end else if (pos >= 0 && pos <= B) begin
                    pos++;
                end else begin
                    pos = -1;
                end
                if (take) mq.push_back(parallel_in);
            end
        end

        // Per-cycle status checks plus frame reassembly against the expected-item queue
        always @(negedge clk) begin
            if (reset) begin
                chk("rst_count",  g, 64'(cnt_w[g]),  64'd0);
                chk("rst_busy",   g, 64'(busy_w[g]), 64'd0);
                chk("rst_ovf",    g, 64'(ovf_w[g]),  64'd0);
                chk("rst_serial", g, 64'(ser_w[g]),  64'd0);
                chk("rst_active", g, 64'(act_w[g]),  64'd0);
                chk("rst_done",   g, 64'(done_w[g]), 64'd0);
                mpos = -1;
            end else begin
                chk("count",        g, 64'(cnt_w[g]),  64'(mq.size()));
                chk("tx_busy",      g, 64'(busy_w[g]), 64'(mq.size() == int'(DEPTH)));
                chk("overflow",     g, 64'(ovf_w[g]),  64'(ovf));
                chk("frame_active", g, 64'(act_w[g]),  64'(pos >= 0 && pos <= B));
                chk("frame_done",   g, 64'(done_w[g]), 64'(pos == B + 1));
                if (pos < 0) chk("idle_serial", g, 64'(ser_w[g]), 64'd0);

                if (mpos < 0) begin
                    if (act_w[g]) begin
                        chk("start_beat", g, 64'(ser_w[g]), 64'(ONES));
                        mpos = 1;
                        acc  = '0;
                    end
                end else if (mpos <= B) begin
                    acc = acc | (40'(ser_w[g] & ONES) << ((mpos - 1) * L));
                    mpos++;
                end else begin
                    chk("stop_serial", g, 64'(ser_w[g]), 64'd0);
                    chk("stop_done",   g, 64'(done_w[g]), 64'd1);
                    chk("frame_pending", g, 64'(exq.size() > 0), 64'd1);
                    if (exq.size() > 0) chk("frame_data", g, 64'(acc), 64'(exq.pop_front()));
                    mpos = -1;
                end

                if (end_chk && !ended) begin
                    ended = 1'b1;
                    chk("drain_fifo",   g, 64'(mq.size()),  64'd0);
                    chk("drain_frames", g, 64'(exq.size()), 64'd0);
                    chk("drain_idle",   g, 64'(mpos < 0),   64'd1);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        req         = 1'b1;
        parallel_in = v;
        step(1);
        req         = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] rnd_item();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[WIDTH-1:0];
    endfunction

    initial begin
        step(3);
        reset = 1'b0;
        en    = 1'b1;

        // Single 0x5 item: first push lands on first edge after reset release
        push(40'h00_0000_0005);
        step(50);

        // Nibble-ordering item for the four-lane instance
        push(40'h12_3456_78AB);
        step(50);

        // Fill past capacity while the receiver holds off, then drain in order
        channel_busy = 1'b1;
        for (int i = 0; i < 9; i++) push(rnd_item());
        step(5);
        channel_busy = 1'b0;
        step(8 * 42 + 20);

        // Backpressure raised mid-frame must not disturb the frame in flight
        push(rnd_item());
        push(rnd_item());
        step(10);
        channel_busy = 1'b1;
        step(60);
        channel_busy = 1'b0;
        step(100);

        // Random traffic: pointer wrap, simultaneous push/pop, en and backpressure toggling
        for (int i = 0; i < 2000; i++) begin
            req          = ($urandom_range(0, 9) < 6);
            parallel_in  = rnd_item();
            en           = ($urandom_range(0, 7) != 0);
            channel_busy = ($urandom_range(0, 4) == 0);
            step(1);
        end
        req          = 1'b0;
        en           = 1'b1;
        channel_busy = 1'b0;
        step(400);

        // Reset in the middle of a frame with items still queued
        channel_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(rnd_item());
        channel_busy = 1'b0;
        step(22);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(60);

        end_chk = 1'b1;
        step(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
